// File: rtl/vga_rx.sv
// vga_rx: receive side of the VGA link.
// Recovers pixel position/colour and supervises line/frame timing.
module vga_rx #(
  parameter int PIX_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        HS,
  input  logic        VS,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_color,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [7:0]  err_count
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_LAST  = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_LAST  = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  logic          hs_q, hs_qq, vs_q, vs_qq;
  logic [11:0]   rgb_q;
  logic          hs_fall, vs_fall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_q  <= 1'b1;
      hs_qq <= 1'b1;
      vs_q  <= 1'b1;
      vs_qq <= 1'b1;
      rgb_q <= '0;
    end else begin
      hs_q  <= HS;
      hs_qq <= hs_q;
      vs_q  <= VS;
      vs_qq <= vs_q;
      rgb_q <= {R, G, B};
    end
  end

  assign hs_fall = !hs_q && hs_qq;
  assign vs_fall = !vs_q && vs_qq;

  logic [DW-1:0] div_q, div_d, ph;
  logic [10:0]   hcnt_q, hcnt_d, hpos;
  logic [9:0]    vcnt_q, vcnt_d, lines;
  logic          tick, bad_line, bad_frame, in_win;

  // The HS-fall clock is phase 0 / column 0 of the new line, so a
  // pending tick from the old line is dropped and never counted.
  always_comb begin
    ph     = hs_fall ? '0 : div_q;
    tick   = (ph == DIV_LAST);
    div_d  = tick ? '0 : ph + DW'(1);
    hpos   = hs_fall ? '0 : hcnt_q;
    hcnt_d = hpos;
    if (tick && hpos != 11'h7ff)
      hcnt_d = hpos + 11'd1;
    lines  = vcnt_q;
    if (hs_fall && vcnt_q != 10'h3ff)
      lines = vcnt_q + 10'd1;
    vcnt_d    = vs_fall ? '0 : lines;
    bad_line  = hs_fall && (hcnt_q != H_TOT);
    bad_frame = vs_fall && (lines != V_TOT);
    in_win    = (hpos >= H_START) && (hpos <= H_LAST) &&
                (vcnt_d >= V_START) && (vcnt_d <= V_LAST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  state_e state_q, state_d;
  logic   frame_ok_q, frame_ok_d;
  logic   err;

  always_comb begin
    state_d    = state_q;
    frame_ok_d = frame_ok_q;
    err        = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d    = MEASURE;
          frame_ok_d = 1'b1;
        end
      end
      MEASURE: begin
        if (bad_line)
          frame_ok_d = 1'b0;
        if (vs_fall) begin
          if (frame_ok_q && !bad_line && !bad_frame)
            state_d = LOCKED;
          else
            frame_ok_d = 1'b1;
        end
      end
      LOCKED: begin
        if (bad_line || bad_frame) begin
          state_d = SEARCH;
          err     = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  logic        cap;
  logic        pix_valid_q, frame_start_q, locked_q, timing_err_q;
  logic [9:0]  pix_x_q, pix_y_q;
  logic [11:0] pix_color_q;
  logic [7:0]  err_count_q;

  assign cap = tick && in_win && (state_q == LOCKED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= SEARCH;
      frame_ok_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_color_q   <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      frame_ok_q    <= frame_ok_d;
      pix_valid_q   <= cap;
      frame_start_q <= vs_fall;
      locked_q      <= (state_d == LOCKED);
      timing_err_q  <= err;
      if (cap) begin
        pix_x_q     <= 10'(hpos - H_START);
        pix_y_q     <= vcnt_d - V_START;
        pix_color_q <= rgb_q;
      end
      if (err && err_count_q != 8'hff)
        err_count_q <= err_count_q + 8'd1;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_color   = pix_color_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed frames on a tiny raster for vga_rx.
// Drives sync/colour like the transmitter and checks strobes and lock.
module tb_vga_rx;

  localparam int PD  = 2;
  localparam int HSY = 2;
  localparam int HBK = 2;
  localparam int HAC = 4;
  localparam int HTO = 10;
  localparam int VSY = 1;
  localparam int VBK = 1;
  localparam int VAC = 3;
  localparam int VTO = 6;

  logic        clk;
  logic        rst_n;
  logic        HS, VS;
  logic [3:0]  R, G, B;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_color;
  logic        frame_start, locked, timing_err;
  logic [7:0]  err_count;

  vga_rx #(
    .PIX_DIV(PD), .H_SYNC(HSY), .H_BACK(HBK),
    .H_ACTIVE(HAC), .H_TOTAL(HTO), .V_SYNC(VSY),
    .V_BACK(VBK), .V_ACTIVE(VAC), .V_TOTAL(VTO)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .HS(HS),
    .VS(VS),
    .R(R),
    .G(G),
    .B(B),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_color(pix_color),
    .frame_start(frame_start),
    .locked(locked),
    .timing_err(timing_err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fs_n  = 0;
  int te_n  = 0;
  logic [31:0] q[$];

  always @(negedge clk) begin
    if (pix_valid) q.push_back({pix_x, pix_y, pix_color});
    if (frame_start) fs_n++;
    if (timing_err) te_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] col(input int x, input int y,
                                      input int s);
    logic [3:0] a, b, c;
    a = 4'(x + s);
    b = 4'(3 * y + s);
    c = 4'(15 - x - s);
    return {a, b, c};
  endfunction

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_x"}, 32'(pix_x), 32'd0);
    chk({tag, "_y"}, 32'(pix_y), 32'd0);
    chk({tag, "_color"}, 32'(pix_color), 32'd0);
    chk({tag, "_fstart"}, 32'(frame_start), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_terr"}, 32'(timing_err), 32'd0);
    chk({tag, "_errcnt"}, 32'(err_count), 32'd0);
  endtask

  // one frame of nl lines; line short_l is 9 pixels; reset pulled
  // low at (rst_l, rst_p) and released at the start of line rst_l+1
  task automatic drive_frame(input int nl, input int short_l,
                             input int s, input int rst_l,
                             input int rst_p);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == short_l) ? HTO - 1 : HTO;
      for (int p = 0; p < len; p++) begin
        for (int d = 0; d < PD; d++) begin
          logic act;
          @(negedge clk);
          if (rst_l >= 0 && l == rst_l + 1 && p == 0 && d == 0)
            rst_n = 1'b1;
          act = (l >= VSY + VBK) && (l < VSY + VBK + VAC) &&
                (p >= HSY + HBK) && (p < HSY + HBK + HAC);
          HS = (p < HSY) ? 1'b0 : 1'b1;
          VS = (l < VSY) ? 1'b0 : 1'b1;
          {R, G, B} = act ? col(p - HSY - HBK, l - VSY - VBK, s)
                          : 12'h000;
          if (l == rst_l && p == rst_p && d == 0) begin
            #2;
            chk("pre_rst_locked", 32'(locked), 32'd1);
            chk("pre_rst_errcnt", 32'(err_count), 32'd2);
            rst_n = 1'b0;
            #1;
            chk_zero_outs("async_rst");
          end
        end
      end
    end
  endtask

  task automatic check_frame(input int s, input int nrows);
    chk("strobes", 32'(q.size()), 32'(nrows * HAC));
    for (int y = 0; y < nrows; y++) begin
      for (int x = 0; x < HAC; x++) begin
        int idx;
        logic [31:0] g;
        idx = y * HAC + x;
        g = (idx < q.size()) ? q[idx] : 32'hffff_ffff;
        chk("pix", g, {10'(x), 10'(y), col(x, y, s)});
      end
    end
    q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    HS = 1'b1;
    VS = 1'b1;
    R = '0;
    G = '0;
    B = '0;
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_locked", 32'(locked), 32'd0);

    drive_frame(VTO, -1, 1, -1, 0);
    chk("A_locked", 32'(locked), 32'd0);
    check_frame(1, 0);

    drive_frame(VTO, -1, 2, -1, 0);
    chk("B_locked", 32'(locked), 32'd1);
    check_frame(2, VAC);

    drive_frame(VTO, -1, 3, -1, 0);
    chk("C_terr", 32'(te_n), 32'd0);
    check_frame(3, VAC);

    drive_frame(VTO, 3, 4, -1, 0);
    chk("D_terr", 32'(te_n), 32'd1);
    chk("D_errcnt", 32'(err_count), 32'd1);
    chk("D_locked", 32'(locked), 32'd0);
    check_frame(4, 2);

    drive_frame(VTO, -1, 5, -1, 0);
    chk("E_locked", 32'(locked), 32'd0);
    check_frame(5, 0);

    drive_frame(VTO, -1, 6, -1, 0);
    chk("F_locked", 32'(locked), 32'd1);
    chk("F_errcnt", 32'(err_count), 32'd1);
    check_frame(6, VAC);

    drive_frame(VTO + 1, -1, 7, -1, 0);
    chk("G_locked", 32'(locked), 32'd1);
    chk("G_terr", 32'(te_n), 32'd1);
    check_frame(7, VAC);

    drive_frame(VTO, -1, 8, -1, 0);
    chk("H_terr", 32'(te_n), 32'd2);
    chk("H_errcnt", 32'(err_count), 32'd2);
    chk("H_locked", 32'(locked), 32'd0);
    check_frame(8, 0);

    drive_frame(VTO, -1, 9, -1, 0);
    chk("I_locked", 32'(locked), 32'd0);
    check_frame(9, 0);

    drive_frame(VTO, -1, 10, -1, 0);
    chk("J_locked", 32'(locked), 32'd1);
    check_frame(10, VAC);

    drive_frame(VTO, -1, 11, 3, 2);
    chk("K_locked", 32'(locked), 32'd0);
    chk("K_errcnt", 32'(err_count), 32'd0);
    check_frame(11, 1);

    drive_frame(VTO, -1, 12, -1, 0);
    chk("L_locked", 32'(locked), 32'd0);
    check_frame(12, 0);

    drive_frame(VTO, -1, 13, -1, 0);
    chk("M_locked", 32'(locked), 32'd1);
    check_frame(13, VAC);

    chk("frame_starts", 32'(fs_n), 32'd13);
    chk("terr_total", 32'(te_n), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
